// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed seven-segment scan driver:
//   - SEG_OFF       : all-off pattern for the active-low segment/select buses
//   - scan_state_e  : two-state scan FSM encoding (BLANK gap, LIT digit)
//   - HEX7_TABLE    : active-high gfedcba pattern for each hex nibble
//   - lz_blank_mask : per-digit leading-zero blank flags for a 32-bit value
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic {
        BLANK = 1'b0,
        LIT   = 1'b1
    } scan_state_e;

    // Entry n is the pattern for nibble n; MSB-first concatenation, so F is first.
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    // Bit k set when digit k is a leading zero, i.e. every nibble from k upward
    // is zero. Digit 0 is never blanked so a zero value still shows "0".
    function automatic logic [7:0] lz_blank_mask(input logic [31:0] value);
        logic [7:0] mask;
        mask = 8'h00;
        for (int k = 1; k < 8; k++) begin
            mask[k] = ((value >> (4 * k)) == 32'd0);
        end
        return mask;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex nibble to seven-segment decoder.
// Ports:
//   nibble  in   4  hex digit value
//   seg     out  7  active-high segment pattern {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX7_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Scans a latched 32-bit value onto an 8-digit multiplexed seven-segment
// display, one hex digit at a time, with a one-cycle all-off gap between
// digits to avoid ghosting. A stop input freezes the latched value.
// Parameters:
//   DIGIT_PERIOD  clk cycles per digit including the blank cycle (>= 2)
//   LZ_SUPPRESS   1 = blank leading zero digits (digit 0 never blanked)
// Ports:
//   clk         in   1   system clock, rising edge
//   rst         in   1   asynchronous active-low reset
//   stop        in   1   1 = hold shown, ignore data_valid
//   data_in     in   32  value to display, nibble k -> digit k
//   data_valid  in   1   load strobe for data_in
//   dp_mask     in   8   decimal point per digit, 1 = lit
//   o_seg       out  8   {dp,g,f,e,d,c,b,a}, active-low, registered
//   o_sel       out  8   digit enable, active-low one-hot, registered
//   shown       out  32  value currently latched for display
//   digit_idx   out  3   digit currently being scanned
// ---------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_PERIOD = 50000,
    parameter bit LZ_SUPPRESS  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stop,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel,
    output logic [31:0] shown,
    output logic [2:0]  digit_idx
);

    localparam int CNT_W = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_PERIOD - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       digit_idx_q, digit_idx_d;
    logic [31:0]      shown_q, shown_d;
    logic [7:0]       o_seg_q, o_seg_d;
    logic [7:0]       o_sel_q, o_sel_d;

    logic             tick;
    logic [3:0]       cur_nibble;
    logic [6:0]       cur_pattern;
    logic [7:0]       lz_mask;
    logic             digit_blank;

    assign tick = (cnt_q == CNT_LAST);

    // Decode the digit selected this cycle; the result lands in the output
    // register, so the display lags the scan state by one cycle.
    assign cur_nibble = shown_q[4 * digit_idx_q +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (cur_nibble),
        .seg    (cur_pattern)
    );

    assign lz_mask     = lz_blank_mask(shown_q);
    assign digit_blank = LZ_SUPPRESS && lz_mask[digit_idx_q];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // BLANK always lasts a single cycle; LIT ends on the prescaler tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK:   state_d = LIT;
            LIT:     if (tick) state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // A leading-zero digit stays selected with its segments dark, but its
    // decimal point still follows dp_mask.
    always_comb begin
        o_sel_d = SEG_OFF;
        o_seg_d = SEG_OFF;
        if (state_q == LIT) begin
            o_sel_d = ~(8'b1 << digit_idx_q);
            o_seg_d = ~{dp_mask[digit_idx_q], (digit_blank ? 7'h00 : cur_pattern)};
        end
    end

    // ---------------- Datapath next values ----------------
    always_comb begin
        shown_d = shown_q;
        if (data_valid && !stop) begin
            shown_d = data_in;
        end

        // Entering BLANK restarts the count, so a digit gets one BLANK cycle
        // (cnt=0) followed by LIT cycles cnt=1..DIGIT_PERIOD-1.
        cnt_d = cnt_q + CNT_W'(1);
        if (tick || state_d == BLANK) begin
            cnt_d = '0;
        end

        digit_idx_d = digit_idx_q;
        if (state_q == LIT && tick) begin
            digit_idx_d = digit_idx_q + 3'd1;
        end
    end

    // ---------------- Datapath and output registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            digit_idx_q <= 3'd0;
            shown_q     <= 32'd0;
            o_seg_q     <= SEG_OFF;
            o_sel_q     <= SEG_OFF;
        end else begin
            cnt_q       <= cnt_d;
            digit_idx_q <= digit_idx_d;
            shown_q     <= shown_d;
            o_seg_q     <= o_seg_d;
            o_sel_q     <= o_sel_d;
        end
    end

    assign o_seg     = o_seg_q;
    assign o_sel     = o_sel_q;
    assign shown     = shown_q;
    assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver with DIGIT_PERIOD=4 and an 8 ns
// clock. Expected display cycles are pushed to a queue as stimulus is driven
// and a negedge monitor pops and compares one record per clock.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic        data_valid = 1'b0;
    logic [7:0]  dp_mask = 8'd0;
    logic [7:0]  o_seg;
    logic [7:0]  o_sel;
    logic [31:0] shown;
    logic [2:0]  digit_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #4 clk = ~clk;

    seg7_scan_driver #(
        .DIGIT_PERIOD (P),
        .LZ_SUPPRESS  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stop       (stop),
        .data_in    (data_in),
        .data_valid (data_valid),
        .dp_mask    (dp_mask),
        .o_seg      (o_seg),
        .o_sel      (o_sel),
        .shown      (shown),
        .digit_idx  (digit_idx)
    );

    typedef struct packed {
        logic [7:0] sel;
        logic [7:0] seg;
    } obs_t;

    // segs holds the expected LIT o_seg of digit k in bits [8k+7:8k].
    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [63:0] segs;
    } vec_t;

    obs_t sb_q[$];
    vec_t vecs[8];

    localparam logic [63:0] ZERO_SEGS = 64'hFF_FF_FF_FF_FF_FF_FF_C0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: one-hot-low select every cycle, plus scoreboard compare.
    always @(negedge clk) begin
        obs_t e;
        n_checks++;
        if ($countones(~o_sel) > 1) begin
            n_fail++;
            $display("FAIL onehot: o_sel=%h has more than one active bit", o_sel);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (o_sel !== e.sel || o_seg !== e.seg) begin
                n_fail++;
                $display("FAIL scan t=%0t: o_sel=%h o_seg=%h, want o_sel=%h o_seg=%h",
                         $time, o_sel, o_seg, e.sel, e.seg);
            end
        end
    end

    // Queue one sweep: optional leading gap, then per digit 3 LIT cycles with
    // a gap in front of every digit after the first.
    task automatic push_sweep(input logic [63:0] segs, input bit lead_gap);
        obs_t r;
        for (int d = 0; d < 8; d++) begin
            if (d != 0 || lead_gap) begin
                r.sel = 8'hFF;
                r.seg = 8'hFF;
                sb_q.push_back(r);
            end
            for (int c = 0; c < P - 1; c++) begin
                r.sel = ~(8'd1 << d);
                r.seg = segs[8 * d +: 8];
                sb_q.push_back(r);
            end
        end
    endtask

    task automatic wait_sel(input logic [7:0] want, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_sel !== want && n < 200);
        if (o_sel !== want) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout %s: o_sel=%h, want %h", name, o_sel, want);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout %s: %0d records left, want 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        @(negedge clk);
        data_in    = v.data;
        dp_mask    = v.dp;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        check({name, "_shown"}, shown, v.data);
        // Align to the gap in front of digit 0, then expect a full sweep.
        wait_sel(8'h7F, name);
        wait_sel(8'hFF, name);
        #2;
        push_sweep(v.segs, 1'b0);
        drain(name);
    endtask

    task automatic wait_idx(input logic [2:0] idx, input logic [7:0] sel, input bit use_sel,
                            input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(digit_idx == idx && (!use_sel || o_sel == sel)) && n < 200);
        if (!(digit_idx == idx && (!use_sel || o_sel == sel))) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout %s: digit_idx=%0d o_sel=%h, want idx %0d", name, digit_idx,
                     o_sel, idx);
        end
    endtask

    initial begin
        obs_t r;
        vecs[0] = '{32'h1234ABCD, 8'h00, 64'hF9_A4_B0_99_88_83_C6_A1};
        vecs[1] = '{32'h000000F0, 8'h00, 64'hFF_FF_FF_FF_FF_FF_8E_C0};
        vecs[2] = '{32'h000000F0, 8'h01, 64'hFF_FF_FF_FF_FF_FF_8E_40};
        vecs[3] = '{32'hDEADBEEF, 8'h00, 64'hA1_86_88_A1_83_86_86_8E};
        vecs[4] = '{32'h00000000, 8'h80, 64'h7F_FF_FF_FF_FF_FF_FF_C0};
        vecs[5] = '{32'h80000000, 8'h00, 64'h80_C0_C0_C0_C0_C0_C0_C0};
        vecs[6] = '{32'h01000000, 8'h00, 64'hFF_F9_C0_C0_C0_C0_C0_C0};
        vecs[7] = '{32'h56789000, 8'h00, 64'h92_82_F8_80_90_C0_C0_C0};

        // Reset state, then the first sweep of a zero value.
        repeat (2) @(negedge clk);
        check("rst_o_seg", o_seg, 8'hFF);
        check("rst_o_sel", o_sel, 8'hFF);
        check("rst_shown", shown, 32'd0);
        check("rst_idx", digit_idx, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        push_sweep(ZERO_SEGS, 1'b1);
        drain("post_reset");

        for (int i = 0; i < 3; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Load is ignored while stopped.
        @(negedge clk);
        stop       = 1'b1;
        data_in    = 32'hDEADBEEF;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        check("stop_hold", shown, 32'h000000F0);
        @(negedge clk);
        check("stop_hold2", shown, 32'h000000F0);
        stop = 1'b0;

        for (int i = 3; i < 8; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Load on the same edge as the digit-2 -> digit-3 tick.
        wait_idx(3'd2, 8'hFF, 1'b1, "tick_align");
        @(negedge clk);
        @(negedge clk);
        data_in    = 32'h0000A000;
        data_valid = 1'b1;
        #2;
        r = '{8'hFB, 8'hC0}; sb_q.push_back(r);
        r = '{8'hFF, 8'hFF}; sb_q.push_back(r);
        for (int c = 0; c < P - 1; c++) begin
            r = '{8'hF7, 8'h88};
            sb_q.push_back(r);
        end
        @(negedge clk);
        data_valid = 1'b0;
        check("tick_load_idx", digit_idx, 3'd3);
        check("tick_load_shown", shown, 32'h0000A000);
        drain("tick_load");

        // Asynchronous reset in the middle of digit 5.
        wait_idx(3'd5, 8'h00, 1'b0, "mid_reset");
        #1;
        rst = 1'b0;
        #1;
        check("async_o_sel", o_sel, 8'hFF);
        check("async_o_seg", o_seg, 8'hFF);
        check("async_idx", digit_idx, 3'd0);
        check("async_shown", shown, 32'd0);
        @(negedge clk);
        dp_mask = 8'h00;
        rst     = 1'b1;
        #2;
        push_sweep(ZERO_SEGS, 1'b1);
        drain("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
